// File: rtl/mypackage.sv
// Shared phase-accumulator types.
// Defines the phase index width and its vector type.
package mypackage;

    localparam int PHASE_INDEX_BITS = 16;

    typedef logic [PHASE_INDEX_BITS-1:0] phase_index_type;

endpackage

// File: rtl/phase_generator.sv
// Phase accumulator with jump / portamento increment control.
// Ports: clock, reset_n, sample_en, target_inc, inc_valid, glide_en,
// phase_sync in; phase, phase_valid, wrap, gliding out (all registered).
module phase_generator
    import mypackage::*;
#(
    parameter int unsigned GLIDE_SHIFT = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            sample_en,
    input  phase_index_type target_inc,
    input  logic            inc_valid,
    input  logic            glide_en,
    input  logic            phase_sync,
    output phase_index_type phase,
    output logic            phase_valid,
    output logic            wrap,
    output logic            gliding
);

    localparam int W = PHASE_INDEX_BITS;

    typedef enum logic {
        STEADY = 1'b0,
        GLIDE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    phase_index_type phase_q, phase_d;
    phase_index_type cur_inc_q, cur_inc_d;
    phase_index_type tgt_inc_q, tgt_inc_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic            gliding_q;

    logic            carry;
    phase_index_type sum;
    logic signed [W:0] diff;
    logic signed [W:0] step;
    phase_index_type cur_stepped;

    assign {carry, sum} = {1'b0, phase_q} + {1'b0, cur_inc_q};

    // Step is a fraction of the remaining error; once the shift rounds
    // it to zero, crawl one unit so the glide always terminates.
    // The floor shift never exceeds |diff|, so no overshoot is possible.
    always_comb begin
        diff = $signed({1'b0, tgt_inc_q}) - $signed({1'b0, cur_inc_q});
        step = diff >>> GLIDE_SHIFT;
        if (step == '0) begin
            step = diff[W] ? -'sd1 : 'sd1;
        end
    end

    assign cur_stepped = cur_inc_q + step[W-1:0];

    always_comb begin
        phase_d   = phase_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        cur_inc_d = cur_inc_q;
        tgt_inc_d = tgt_inc_q;
        state_d   = state_q;

        if (phase_sync) begin
            phase_d = '0;
            valid_d = 1'b1;
        end else if (sample_en) begin
            phase_d = sum;
            valid_d = 1'b1;
            wrap_d  = carry;
        end

        // A new load pre-empts any glide step on the same edge.
        if (inc_valid) begin
            tgt_inc_d = target_inc;
            if (!glide_en) begin
                cur_inc_d = target_inc;
                state_d   = STEADY;
            end else if (target_inc != cur_inc_q) begin
                state_d = GLIDE;
            end else begin
                state_d = STEADY;
            end
        end else if (state_q == GLIDE && sample_en) begin
            cur_inc_d = cur_stepped;
            if (cur_stepped == tgt_inc_q) begin
                state_d = STEADY;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= STEADY;
            phase_q   <= '0;
            cur_inc_q <= '0;
            tgt_inc_q <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            gliding_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cur_inc_q <= cur_inc_d;
            tgt_inc_q <= tgt_inc_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            gliding_q <= (state_d == GLIDE);
        end
    end

    assign phase       = phase_q;
    assign phase_valid = valid_q;
    assign wrap        = wrap_q;
    assign gliding     = gliding_q;

endmodule

// File: tb/tb_phase_generator.sv
// Directed bench for phase_generator: vector table plus corner sequences.
// Two instances: GLIDE_SHIFT=2 (main) and GLIDE_SHIFT=0 (downward glide).
module tb_phase_generator;
    import mypackage::*;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            sample_en = 1'b0;
    phase_index_type target_inc = '0;
    logic            inc_valid = 1'b0;
    logic            glide_en = 1'b0;
    logic            phase_sync = 1'b0;

    phase_index_type phase, phase0;
    logic            pv, pv0, wr, wr0, gl, gl0;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    phase_generator #(.GLIDE_SHIFT(2)) dut (
        .clock(clock), .reset_n(reset_n), .sample_en(sample_en),
        .target_inc(target_inc), .inc_valid(inc_valid),
        .glide_en(glide_en), .phase_sync(phase_sync),
        .phase(phase), .phase_valid(pv), .wrap(wr), .gliding(gl)
    );

    phase_generator #(.GLIDE_SHIFT(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .sample_en(sample_en),
        .target_inc(target_inc), .inc_valid(inc_valid),
        .glide_en(glide_en), .phase_sync(phase_sync),
        .phase(phase0), .phase_valid(pv0), .wrap(wr0), .gliding(gl0)
    );

    typedef struct {
        logic        se, iv, ge, sy;
        logic [15:0] tgt;
        logic [15:0] ph;
        logic        v, w, g;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic se, logic iv, logic ge, logic sy,
                                logic [15:0] tgt, logic [15:0] ph,
                                logic v, logic w, logic g);
        vec_t r;
        r.se = se; r.iv = iv; r.ge = ge; r.sy = sy; r.tgt = tgt;
        r.ph = ph; r.v = v; r.w = w; r.g = g;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic se, logic iv, logic ge, logic sy,
                         logic [15:0] tgt);
        sample_en  = se;
        inc_valid  = iv;
        glide_en   = ge;
        phase_sync = sy;
        target_inc = tgt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 16'h0);
    endtask

    logic [15:0] exp_cur[10];
    logic [15:0] eph;
    logic [15:0] ecur;

    initial begin
        exp_cur = '{16'd4, 16'd7, 16'd9, 16'd10, 16'd11,
                    16'd12, 16'd13, 16'd14, 16'd15, 16'd16};

        vt[0]  = mk(0, 1, 0, 0, 16'h0100, 16'h0000, 0, 0, 0);
        vt[1]  = mk(1, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 16'h0000, 16'h0100, 0, 0, 0);
        vt[3]  = mk(1, 0, 0, 0, 16'h0000, 16'h0200, 1, 0, 0);
        vt[4]  = mk(1, 0, 0, 0, 16'h0000, 16'h0300, 1, 0, 0);
        vt[5]  = mk(0, 0, 0, 0, 16'h0000, 16'h0300, 0, 0, 0);
        vt[6]  = mk(0, 1, 0, 1, 16'h4000, 16'h0000, 1, 0, 0);
        vt[7]  = mk(1, 0, 0, 0, 16'h0000, 16'h4000, 1, 0, 0);
        vt[8]  = mk(1, 0, 0, 0, 16'h0000, 16'h8000, 1, 0, 0);
        vt[9]  = mk(1, 0, 0, 0, 16'h0000, 16'hC000, 1, 0, 0);
        vt[10] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
        vt[11] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        vt[12] = mk(1, 1, 0, 1, 16'h0010, 16'h0000, 1, 0, 0);
        vt[13] = mk(1, 0, 0, 0, 16'h0000, 16'h0010, 1, 0, 0);
        vt[14] = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0);
        vt[15] = mk(1, 1, 0, 0, 16'h0020, 16'h0010, 1, 0, 0);
        vt[16] = mk(1, 0, 0, 0, 16'h0000, 16'h0030, 1, 0, 0);

        #12;
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_valid", 32'(pv), 32'h0);
        chk("rst_wrap", 32'(wr), 32'h0);
        chk("rst_gliding", 32'(gl), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].se, vt[i].iv, vt[i].ge, vt[i].sy, vt[i].tgt);
            tick();
            chk($sformatf("vec%0d_phase", i), 32'(phase), 32'(vt[i].ph));
            chk($sformatf("vec%0d_valid", i), 32'(pv), 32'(vt[i].v));
            chk($sformatf("vec%0d_wrap", i), 32'(wr), 32'(vt[i].w));
            chk($sformatf("vec%0d_glide", i), 32'(gl), 32'(vt[i].g));
        end

        // Upward glide 0 -> 16 with GLIDE_SHIFT=2.
        drive(0, 1, 0, 1, 16'h0000);
        tick();
        drive(0, 1, 1, 0, 16'd16);
        tick();
        chk("glide_start", 32'(gl), 32'h1);
        eph  = 16'h0;
        ecur = 16'h0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, 16'h0);
            tick();
            eph  = eph + ecur;
            ecur = exp_cur[k];
            chk($sformatf("glide%0d_phase", k), 32'(phase), 32'(eph));
            chk($sformatf("glide%0d_gl", k), 32'(gl), (k < 9) ? 32'h1 : 32'h0);
        end
        drive(1, 0, 0, 0, 16'h0);
        tick();
        chk("glide_final_phase", 32'(phase), 32'(eph + 16'd16));

        // Downward glide 8 -> 3 on the GLIDE_SHIFT=0 instance.
        drive(0, 1, 0, 1, 16'd8);
        tick();
        drive(0, 1, 1, 0, 16'd3);
        tick();
        chk("down_start_gl", 32'(gl0), 32'h1);
        drive(1, 0, 0, 0, 16'h0);
        tick();
        chk("down_gl_off", 32'(gl0), 32'h0);
        chk("down_phase1", 32'(phase0), 32'd8);
        drive(1, 0, 0, 0, 16'h0);
        tick();
        chk("down_phase2", 32'(phase0), 32'd11);

        // Asynchronous reset in the middle of a glide.
        drive(0, 1, 1, 0, 16'h1000);
        tick();
        drive(1, 0, 0, 0, 16'h0);
        tick();
        chk("pre_rst_gl", 32'(gl), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 32'h0);
        chk("arst_valid", 32'(pv), 32'h0);
        chk("arst_wrap", 32'(wr), 32'h0);
        chk("arst_gl", 32'(gl), 32'h0);
        drive(1, 1, 0, 0, 16'h0040);
        @(posedge clock);
        #1;
        chk("in_rst_phase", 32'(phase), 32'h0);
        chk("in_rst_valid", 32'(pv), 32'h0);
        drive(0, 0, 0, 0, 16'h0);
        #2;
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 16'h0);
        tick();
        chk("post_rst_phase", 32'(phase), 32'h0);
        chk("post_rst_valid", 32'(pv), 32'h1);
        chk("post_rst_gl", 32'(gl), 32'h0);
        drive(1, 0, 0, 0, 16'h0);
        tick();
        chk("post_rst_phase2", 32'(phase), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
